// File: rtl/lead_one_pkg.sv
// ---------------------------------------------------------------------------
// lead_one_pkg
//   Shared definitions for the 32-source leading-one scheduler.
//   - SRC_N / IDX_W : number of sources and width of a source index
//   - state_t       : scheduler FSM encoding (IDLE / OFFER / RETIRE)
//   - msb8()        : index of the highest set bit of a byte (0 if none)
// ---------------------------------------------------------------------------
package lead_one_pkg;

    localparam int SRC_N = 32;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        RETIRE = 2'd2
    } state_t;

    // Ascending scan, so the last (highest) set bit wins.
    function automatic logic [2:0] msb8(input logic [7:0] b);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/find_msb32.sv
// ---------------------------------------------------------------------------
// find_msb32
//   Purely combinational 32-bit leading-one search, bit 31 highest priority.
//   The word is split into four bytes: the top non-zero byte supplies
//   idx[4:3], the highest set bit inside that byte supplies idx[2:0].
//
//   Ports:
//     vec  in  32  vector to search
//     idx  out  5  index of the highest set bit (0 when vec == 0)
//     any  out  1  vec has at least one bit set
// ---------------------------------------------------------------------------
module find_msb32
    import lead_one_pkg::*;
(
    input  logic [SRC_N-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [3:0] byte_nz;
    logic [1:0] hi;
    logic [7:0] sel;

    assign byte_nz[0] = |vec[7:0];
    assign byte_nz[1] = |vec[15:8];
    assign byte_nz[2] = |vec[23:16];
    assign byte_nz[3] = |vec[31:24];

    always_comb begin
        hi = 2'd0;
        if (byte_nz[3])      hi = 2'd3;
        else if (byte_nz[2]) hi = 2'd2;
        else if (byte_nz[1]) hi = 2'd1;
    end

    always_comb begin
        sel = vec[7:0];
        case (hi)
            2'd3:    sel = vec[31:24];
            2'd2:    sel = vec[23:16];
            2'd1:    sel = vec[15:8];
            default: sel = vec[7:0];
        endcase
    end

    assign idx = {hi, msb8(sel)};
    assign any = |byte_nz;

endmodule

// File: rtl/lead_one_sched32.sv
// ---------------------------------------------------------------------------
// lead_one_sched32
//   Registered 32-source request scheduler. Request pulses are latched into a
//   sticky pending vector; the highest eligible pending source is offered to
//   a single consumer over a valid/ready handshake.
//
//   Optional feature: define LEAD_ONE_SCHED_RR_EN for round-robin fairness
//   (after granting k, only sources below k are preferred until none remain).
//   Without it the scheduler is pure fixed priority and rr_mask is not built.
//
//   Ports:
//     clk        in   1   clock, all state on the rising edge
//     rst        in   1   synchronous active-high reset
//     req        in  32   request pulses, OR-ed into pending
//     enable     in  32   eligibility mask (ineligible bits stay pending)
//     flush      in   1   pending <= req, drop any offer, FSM to IDLE
//     out_valid  out  1   an index is offered
//     out_idx    out  5   offered index
//     out_ready  in   1   consumer accept
//     pending    out 32   pending register
//     busy       out  1   FSM is not IDLE
//
//   Handshake: a transfer happens on an edge where out_valid && out_ready
//   and flush is low. Once out_valid rises, out_idx stays frozen and
//   out_valid stays high until that transfer (or flush/rst); out_ready is
//   ignored while out_valid is low.
// ---------------------------------------------------------------------------
module lead_one_sched32
    import lead_one_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [SRC_N-1:0] req,
    input  logic [SRC_N-1:0] enable,
    input  logic             flush,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [SRC_N-1:0] pending,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [SRC_N-1:0] elig;
    logic [SRC_N-1:0] clr;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

`ifdef LEAD_ONE_SCHED_RR_EN
    logic [SRC_N-1:0] rr_mask;
    logic [SRC_N-1:0] elig_base;
    logic [SRC_N-1:0] elig_rr;

    assign elig_base = pending & enable;
    assign elig_rr   = elig_base & rr_mask;
    // Nothing left below the last grant: wrap around to the full set.
    assign elig      = (elig_rr != '0) ? elig_rr : elig_base;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_mask <= '1;
        end else if (state == RETIRE) begin
            rr_mask <= (32'd1 << out_idx) - 32'd1;
        end
    end
`else
    assign elig = pending & enable;
`endif

    find_msb32 u_find (
        .vec (elig),
        .idx (win_idx),
        .any (win_any)
    );

    // One-hot clear of the accepted index, only while retiring.
    always_comb begin
        clr = '0;
        if (state == RETIRE) clr[out_idx] = 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush voids any same-cycle acceptance.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (win_any)   state_nxt = OFFER;
                OFFER:   if (out_ready) state_nxt = RETIRE;
                RETIRE:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register only.
    always_comb begin
        out_valid = (state == OFFER);
        busy      = (state != IDLE);
    end

    // Pending vector and offered index. Set beats clear, so a request for
    // the retiring index keeps it pending for re-arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            out_idx <= '0;
        end else begin
            if (flush) pending <= req;
            else       pending <= (pending & ~clr) | req;

            if (!flush && state == IDLE && win_any) out_idx <= win_idx;
        end
    end

endmodule

// File: tb/tb_lead_one_sched32.sv
module tb_lead_one_sched32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic [31:0] enable;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [31:0] pending;
  logic        busy;

  always #5 clk = ~clk;

  lead_one_sched32 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .enable    (enable),
    .flush     (flush),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .pending   (pending),
    .busy      (busy)
  );

  // ---------------- counters / scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  bit          sb_on = 1'b0;

  // ---------------- reference model ----------------
  // m_phase: 0 = waiting, 1 = offering, 2 = retiring
  logic [31:0] m_p   = '0;
  int          m_phase = 0;
  int          m_idx = 0;
  logic [31:0] m_rr  = '1;

  function automatic int top_one(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_elig(input logic [31:0] en);
    logic [31:0] base;
    base = m_p & en;
`ifdef LEAD_ONE_SCHED_RR_EN
    if ((base & m_rr) != 0) return base & m_rr;
`endif
    return base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic r, input logic [31:0] rq, input logic [31:0] en,
                       input logic fl, input logic rd);
    logic [31:0] e;
    logic [31:0] nxt_p;
    rst = r; req = rq; enable = en; flush = fl; out_ready = rd;

    // handshake monitor against the expected grant order
    if (sb_on && !r && !fl && rd && out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_grant", 32'(out_idx), 32'hFFFF_FFFF);
      else                   chk("sb_grant", 32'(out_idx), exp_q.pop_front());
    end

    if (r) begin
      m_p = '0; m_phase = 0; m_idx = 0; m_rr = '1;
    end else if (fl) begin
      m_p = rq; m_phase = 0; m_rr = '1;
    end else begin
      nxt_p = m_p | rq;
      case (m_phase)
        0: begin
          e = m_elig(en);
          if (e != 0) begin
            m_idx = top_one(e);
            m_phase = 1;
          end
        end
        1: if (rd) m_phase = 2;
        default: begin
          nxt_p = (m_p & ~(32'd1 << m_idx)) | rq;
          m_rr = '0;
          for (int k = 0; k < m_idx; k++) m_rr[k] = 1'b1;
          m_phase = 0;
        end
      endcase
      m_p = nxt_p;
    end

    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_phase == 1));
    chk("out_idx",   32'(out_idx),   32'(m_idx));
    chk("pending",   pending,        m_p);
    chk("busy",      32'(busy),      32'(m_phase != 0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; req = '0; enable = '1; flush = 1'b0; out_ready = 1'b0;
    sb_on = 1'b1;

    // reset
    cycle(1'b1, 32'd0, '1, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, '1, 1'b0, 1'b1);
    chk("rst_pending", pending, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);

    // single request, idx 8 offered two cycles after the pulse
    exp_q.push_back(32'd8);
    cycle(1'b0, 32'h0000_0100, '1, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, '1, 1'b0, 1'b1);
    chk("t1_valid_c2", 32'(out_valid), 32'd1);
    chk("t1_idx", 32'(out_idx), 32'd8);
    repeat (3) cycle(1'b0, 32'd0, '1, 1'b0, 1'b1);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);
    chk("t1_pending", pending, 32'd0);

    // priority: 31 then 0
    exp_q.push_back(32'd31);
    exp_q.push_back(32'd0);
    cycle(1'b0, 32'h8000_0001, '1, 1'b0, 1'b1);
    repeat (7) cycle(1'b0, 32'd0, '1, 1'b0, 1'b1);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // backpressure with enable[7] dropped mid-offer
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd4);
    cycle(1'b0, 32'h0000_00F0, '1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, '1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'd0, (i >= 5) ? ~32'h80 : '1, 1'b0, 1'b0);
      chk("t3_idx_held", 32'(out_idx), 32'd7);
    end
    repeat (12) cycle(1'b0, 32'd0, ~32'h80, 1'b0, 1'b1);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // set/clear collision in RETIRE of idx 7
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd7);
    cycle(1'b0, 32'h80, '1, 1'b0, 1'b1);
    for (int i = 0; i < 10 && m_phase != 2; i++) cycle(1'b0, 32'd0, '1, 1'b0, 1'b1);
    cycle(1'b0, 32'h80, '1, 1'b0, 1'b1);
    chk("t4_pend7", 32'(pending[7]), 32'd1);
    repeat (4) cycle(1'b0, 32'd0, '1, 1'b0, 1'b1);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // flush during OFFER with out_ready high and req[2]
    cycle(1'b0, 32'h10, '1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, '1, 1'b0, 1'b0);
    chk("t5_offer4", 32'(out_idx), 32'd4);
    cycle(1'b0, 32'h4, '1, 1'b1, 1'b1);
    chk("t5_pend", pending, 32'h4);
    chk("t5_no_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 32'd0, '1, 1'b0, 1'b0);
    chk("t5_valid2", 32'(out_valid), 32'd1);
    chk("t5_idx2", 32'(out_idx), 32'd2);
    // reset mid-offer
    cycle(1'b1, 32'hFFFF_0000, '1, 1'b0, 1'b1);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_idx", 32'(out_idx), 32'd0);
    chk("t5_rst_pend", pending, 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);

    // fairness: req[31] held, pending[3]
`ifdef LEAD_ONE_SCHED_RR_EN
    exp_q.push_back(32'd31);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd31);
`else
    exp_q.push_back(32'd31);
    exp_q.push_back(32'd31);
    exp_q.push_back(32'd31);
`endif
    cycle(1'b0, 32'h8000_0008, '1, 1'b0, 1'b1);
    for (int i = 0; i < 12 && exp_q.size() > 0; i++)
      cycle(1'b0, 32'h8000_0000, '1, 1'b0, 1'b1);
    chk("t6_drain", 32'(exp_q.size()), 32'd0);
`ifndef LEAD_ONE_SCHED_RR_EN
    chk("t6_starved3", 32'(pending[3]), 32'd1);
`endif
    cycle(1'b0, 32'd0, '1, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, '1, 1'b0, 1'b0);

    // randomized traffic against the model
    sb_on = 1'b0;
    repeat (400) begin
      logic        r_r;
      logic [31:0] r_q;
      logic [31:0] r_e;
      logic        r_f;
      logic        r_d;
      r_r = ($urandom_range(0, 99) == 0);
      r_q = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
      r_e = ($urandom_range(0, 3) == 0) ? $urandom : '1;
      r_f = ($urandom_range(0, 49) == 0);
      r_d = ($urandom_range(0, 2) != 0);
      cycle(r_r, r_q, r_e, r_f, r_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
